// File: rtl/register_file.sv
// register_file: 32-entry, 2-read/1-write GPR file for the MIPS datapath.
// Ports: clk, rst (sync, active-high), WE3/A3/WD3 write, A1/RD1, A2/RD2 read.
// Reg 0 is hardwired to zero; reads are combinational, writes on clk rise.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards WD3 to a matching read
// port in the same cycle.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WE3,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [DATA_WIDTH-1:0] regs_d [NREG];
  logic                  wr_en;

  // writes to reg 0 are dropped here so it never leaves zero
  assign wr_en = WE3 && (A3 != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[A3] = WD3;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    RD1 = (A1 == '0) ? '0 : regs_q[A1];
    RD2 = (A2 == '0) ? '0 : regs_q[A2];
`ifdef REGFILE_WRITE_BYPASS_EN
    // wr_en already excludes A3 == 0, so reg 0 still reads zero
    if (wr_en && !rst && (A3 == A1)) begin
      RD1 = WD3;
    end
    if (wr_en && !rst && (A3 == A2)) begin
      RD2 = WD3;
    end
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed, table-driven check of register_file.
// Covers reset sweep, writes, reg-0 discard, reset priority, same-cycle r/w.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        we3;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int checks;
  int failures;

  register_file dut (
    .clk (clk),
    .rst (rst),
    .WE3 (we3),
    .A1  (a1),
    .A2  (a2),
    .A3  (a3),
    .WD3 (wd3),
    .RD1 (rd1),
    .RD2 (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{0, 1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{0, 0, 5'd5,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{0, 1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[3] = '{0, 0, 5'd7,  32'h12345678, 5'd5,  5'd7,  32'hDEADBEEF, 32'h0};
    vecs[4] = '{0, 1, 5'd31, 32'h80000001, 5'd31, 5'd5,  32'h80000001, 32'hDEADBEEF};
    vecs[5] = '{0, 1, 5'd1,  32'h0000FFFF, 5'd1,  5'd31, 32'h0000FFFF, 32'h80000001};
    vecs[6] = '{0, 1, 5'd5,  32'h11111111, 5'd5,  5'd1,  32'h11111111, 32'h0000FFFF};
    vecs[7] = '{1, 1, 5'd9,  32'hCAFEF00D, 5'd9,  5'd5,  32'h0,        32'h0};
    vecs[8] = '{0, 0, 5'd0,  32'h0,        5'd31, 5'd1,  32'h0,        32'h0};

    rst = 1'b1;
    we3 = 1'b0;
    a1  = '0;
    a2  = '0;
    a3  = '0;
    wd3 = '0;
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i);
      a2 = 5'(31 - i);
      #1;
      check($sformatf("reset_rd1[%0d]", i), rd1, 32'h0);
      check($sformatf("reset_rd2[%0d]", 31 - i), rd2, 32'h0);
    end

    // each vector: drive for one edge, drop write/reset, then read
    for (int v = 0; v < 9; v++) begin
      rst = vecs[v].rst;
      we3 = vecs[v].we;
      a3  = vecs[v].a3;
      wd3 = vecs[v].wd;
      a1  = vecs[v].a1;
      a2  = vecs[v].a2;
      @(posedge clk);
      #1;
      rst = 1'b0;
      we3 = 1'b0;
      #1;
      check($sformatf("vec%0d_rd1", v), rd1, vecs[v].e1);
      check($sformatf("vec%0d_rd2", v), rd2, vecs[v].e2);
    end

    // same-cycle read/write on reg 3 (reg 3 is zero after the reset)
    a1  = 5'd3;
    a2  = 5'd3;
    a3  = 5'd3;
    wd3 = 32'hA5A5A5A5;
    we3 = 1'b1;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rw_pre_rd1", rd1, 32'hA5A5A5A5);
    check("rw_pre_rd2", rd2, 32'hA5A5A5A5);
`else
    check("rw_pre_rd1", rd1, 32'h0);
    check("rw_pre_rd2", rd2, 32'h0);
`endif
    @(posedge clk);
    #1 we3 = 1'b0;
    #1;
    check("rw_post_rd1", rd1, 32'hA5A5A5A5);
    check("rw_post_rd2", rd2, 32'hA5A5A5A5);

    // bypass must not forward a write to reg 0
    a1  = 5'd0;
    a3  = 5'd0;
    wd3 = 32'hFFFFFFFF;
    we3 = 1'b1;
    #1;
    check("wr0_pre_rd1", rd1, 32'h0);
    @(posedge clk);
    #1 we3 = 1'b0;

    // reset held mid-cycle keeps contents until the edge
    a1  = 5'd3;
    rst = 1'b1;
    #1;
    check("rst_pre_rd1", rd1, 32'hA5A5A5A5);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_post_rd1", rd1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
